bcd_conv_sched: RTL and testbench
=================================

# bcd_conv_sched

Sequential binary-to-BCD conversion scheduler that shares one iterative double-dabble engine between two requesters, e.g. the score counter and the countdown timer feeding the on-screen digit renderer. It arbitrates round-robin, captures the winner's operand, and runs one add-3/shift step per clock. It returns three registered BCD digits with a one-cycle done strobe tagged with the served requester. It replaces per-source combinational converters, keeping the long add/shift chain off the VGA pixel path.

## Interface
- N, 9: operand MSB index; operands are N+1 bits wide; N >= 9.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  2  level request per requester; bit i held high until done with done_id == i.
- num0  in  N+1  operand of requester 0; sampled only on the grant edge.
- num1  in  N+1  operand of requester 1; sampled only on the grant edge.
- busy  out  1  high in SHIFT and DONE states.
- grant_id  out  1  requester currently being served; valid while busy.
- done  out  1  one-cycle pulse; digits valid.
- done_id  out  1  requester whose result is on the digit outputs.
- ovf  out  1  operand exceeded 999; digits saturated; updates with done.
- hundreds, tens, ones  out  4 each  BCD result; held until next done.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if req == 0, stay. Otherwise grant one requester. If exactly one bit is set, grant it. If both are set, grant the requester not served last; last pointer resets to 1, so requester 0 wins the first tie. On the grant edge:
  - latch grant_id;
  - load the shift register with the BCD field = 0 and the binary field = selected operand;
  - clear the bit counter;
  - set the saturation flag if the operand > 999;
  - go to SHIFT.
- SHIFT: each cycle, first add 3 to every BCD nibble >= 5 (hundreds, tens, ones, evaluated on pre-add values in the same cycle), then shift the whole (N+13)-bit register left by 1. Increment the counter. After the (N+1)th step, go to DONE.
- DONE: register the result and assert done for one cycle.
  - If the saturation flag is set: hundreds/tens/ones = 9/9/9, ovf = 1.
  - Otherwise: digits from the BCD field, ovf = 0.
  - Also: done_id = grant_id; update the last pointer to grant_id; go to IDLE.
- req is ignored in SHIFT and DONE. A requester must deassert req in the cycle done is high with its id, or it is re-served.
- Operand changes after the grant edge have no effect on the current conversion.
- Arithmetic: nibble add is 4-bit. With the operand <= 999 no nibble overflows. Bits shifted past the hundreds nibble are discarded.
- Reset (any state, including mid-SHIFT): go to IDLE. The aborted conversion produces no done. Output reset values:
  - busy, grant_id, done, done_id, ovf = 0;
  - hundreds, tens, ones = 0;
  - last pointer = 1; counter = 0.

## Timing
- Grant edge E0 (IDLE with req != 0); shift steps on edges E1..E(N+1); done and digits registered on E(N+2). Latency is N+2 cycles: 11 for N = 9.
- busy rises after E0 and falls after E(N+3).
- The earliest next grant is edge E(N+3). Back-to-back throughput is one conversion per N+3 cycles.
- The digit outputs change only on the done edge. They are stable between done pulses.
- done is never high for two consecutive cycles.

## Test plan
- Reset, then req=01 with num0=255 held until done → done high at grant edge + 11 cycles; digits 2/5/5; done_id=0; ovf=0; busy high 12 cycles.
- req=11 held continuously with num0=123, num1=999 → results alternate, starting with done_id=0 (1/2/3), then done_id=1 (9/9/9, ovf=0), repeating. Grants are 12 cycles apart.
- req=10 with num1=1000, then num1=1023 → both conversions give 9/9/9 with ovf=1. Next, num1=0 gives 0/0/0 with ovf=0.
- Change num0 from 45 to 678 one cycle after the grant edge → result is 0/4/5.
- Assert reset for one cycle during the 5th SHIFT cycle → all outputs 0 immediately; no done pulse. With req=01 and num0=7 after release, the result is 0/0/7 with correct latency, and requester 0 wins a tie.
- Requester holds req one cycle past done → second conversion starts at E(N+3) with the same id. Checker confirms done_id matches the served requester and done never exceeds one cycle.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// Shares one iterative double-dabble binary-to-BCD engine between two round-robin requesters.
// Latency: N+2 cycles from the grant edge to the done pulse; one conversion per N+3 cycles back-to-back.
// Backpressure: requests are level-held and are only sampled in IDLE; req is ignored while converting.
module bcd_conv_sched #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req,
   input  logic [N:0]   num0,
   input  logic [N:0]   num1,
   output logic         busy,
   output logic         grant_id,
   output logic         done,
   output logic         done_id,
   output logic         ovf,
   output logic [3:0]   hundreds,
   output logic [3:0]   tens,
   output logic [3:0]   ones
);

   // 12 BCD bits on top of the N+1 binary operand bits
   localparam int W  = N + 13;
   localparam int CW = $clog2(N + 1) + 1;
   localparam logic [N:0] MAX_DEC = (N + 1)'(999);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    sreg;
   logic [W-1:0]    sreg_adj;
   logic [CW-1:0]   cnt;
   logic            sat;
   logic            last;
   logic            gnt_vld;
   logic            gnt_sel;
   logic [N:0]      gnt_num;
   logic            last_step;

   // Round-robin pick: a lone request wins outright, a tie goes to whoever was not served last
   always_comb begin
      gnt_vld = |req;
      gnt_sel = 1'b0;
      case (req)
         2'b01:   gnt_sel = 1'b0;
         2'b10:   gnt_sel = 1'b1;
         2'b11:   gnt_sel = ~last;
         default: gnt_sel = 1'b0;
      endcase
      gnt_num = gnt_sel ? num1 : num0;
   end

   // Add-3 correction on each BCD nibble, all judged on the pre-add values
   always_comb begin
      sreg_adj = sreg;
      for (int k = 0; k < 3; k++) begin
         if (sreg[W-1-4*k -: 4] >= 4'd5)
            sreg_adj[W-1-4*k -: 4] = sreg[W-1-4*k -: 4] + 4'd3;
      end
   end

   assign last_step = (cnt == CW'(N));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: grant from IDLE, N+1 shift steps, then one DONE cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_vld) state_nxt = SHIFT;
         SHIFT:   if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, shift engine, result registers and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg     <= '0;
         cnt      <= '0;
         sat      <= 1'b0;
         last     <= 1'b1;
         busy     <= 1'b0;
         grant_id <= 1'b0;
         done     <= 1'b0;
         done_id  <= 1'b0;
         ovf      <= 1'b0;
         hundreds <= 4'd0;
         tens     <= 4'd0;
         ones     <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // busy stays up through the done-pulse cycle and only drops if no new grant follows
               busy <= gnt_vld;
               if (gnt_vld) begin
                  grant_id <= gnt_sel;
                  sreg     <= {12'b0, gnt_num};
                  cnt      <= '0;
                  sat      <= (gnt_num > MAX_DEC);
               end
            end
            SHIFT: begin
               busy <= 1'b1;
               // bits pushed past the hundreds nibble fall off the top
               sreg <= sreg_adj << 1;
               cnt  <= cnt + CW'(1);
            end
            DONE: begin
               busy     <= 1'b1;
               done     <= 1'b1;
               done_id  <= grant_id;
               last     <= grant_id;
               ovf      <= sat;
               hundreds <= sat ? 4'd9 : sreg[W-1 -: 4];
               tens     <= sat ? 4'd9 : sreg[W-5 -: 4];
               ones     <= sat ? 4'd9 : sreg[W-9 -: 4];
            end
            default: busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: latency, round-robin order, saturation, mid-run reset.
// Expected digits are hand-computed decimal splits of each operand.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_bcd_conv_sched;

   localparam int N = 9;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req;
   logic [N:0]   num0;
   logic [N:0]   num1;
   logic         busy;
   logic         grant_id;
   logic         done;
   logic         done_id;
   logic         ovf;
   logic [3:0]   hundreds;
   logic [3:0]   tens;
   logic [3:0]   ones;

   int n_vec = 0;
   int n_bad = 0;

   int gid;
   int lat;
   int bc;
   int dg;

   always #5 clk = ~clk;

   bcd_conv_sched #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .num0     (num0),
      .num1     (num1),
      .busy     (busy),
      .grant_id (grant_id),
      .done     (done),
      .done_id  (done_id),
      .ovf      (ovf),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input int h, input int t, input int o,
                          input int ov, input int id);
      chk({tag, "_hund"}, 32'(hundreds), h);
      chk({tag, "_tens"}, 32'(tens), t);
      chk({tag, "_ones"}, 32'(ones), o);
      chk({tag, "_ovf"},  32'(ovf), ov);
      chk({tag, "_id"},   32'(done_id), id);
   endtask

   // Takes the grant edge, then waits (bounded) for done. Returns with the done cycle sampled.
   task automatic conv(input logic [1:0] rq_after, input int chg0,
                       output int g, output int l, output int b, output int d0);
      tick;
      g  = int'(grant_id);
      d0 = int'(done);
      b  = busy ? 1 : 0;
      req = rq_after;
      if (chg0 >= 0) num0 = (N + 1)'(chg0);
      l = 0;
      for (int i = 1; i <= 40; i++) begin
         tick;
         if (busy) b++;
         if (done) begin
            l = i;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = 2'b00;
      num0  = '0;
      num1  = '0;
      tick;
      tick;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_gid",  32'(grant_id), 0);
      chk("rst_hund", 32'(hundreds), 0);
      chk("rst_ovf",  32'(ovf), 0);
      reset = 1'b0;

      // single requester, 255
      req  = 2'b01;
      num0 = 10'd255;
      conv(2'b01, -1, gid, lat, bc, dg);
      chk("t1_gid", gid, 0);
      chk("t1_lat", lat, 11);
      chk("t1_busy_cycles", bc, 12);
      chk_res("t1", 2, 5, 5, 0, 0);
      req = 2'b00;
      tick;
      chk("t1_busy_fall", 32'(busy), 0);
      chk("t1_done_single", 32'(done), 0);

      // fresh reset so the tie pointer is back at its reset value
      reset = 1'b1;
      tick;
      reset = 1'b0;
      req  = 2'b11;
      num0 = 10'd123;
      num1 = 10'd999;
      conv(2'b11, -1, gid, lat, bc, dg);
      chk("t2a_gid", gid, 0);
      chk("t2a_lat", lat, 11);
      chk_res("t2a", 1, 2, 3, 0, 0);
      conv(2'b11, -1, gid, lat, bc, dg);
      chk("t2b_done_single", dg, 0);
      chk("t2b_gid", gid, 1);
      chk("t2b_lat", lat, 11);
      chk_res("t2b", 9, 9, 9, 0, 1);
      conv(2'b00, -1, gid, lat, bc, dg);
      chk("t2c_done_single", dg, 0);
      chk("t2c_gid", gid, 0);
      chk("t2c_lat", lat, 11);
      chk_res("t2c", 1, 2, 3, 0, 0);
      tick;

      // saturation
      req  = 2'b10;
      num1 = 10'd1000;
      conv(2'b00, -1, gid, lat, bc, dg);
      chk("t3a_gid", gid, 1);
      chk_res("t3a", 9, 9, 9, 1, 1);
      tick;
      req  = 2'b10;
      num1 = 10'd1023;
      conv(2'b00, -1, gid, lat, bc, dg);
      chk_res("t3b", 9, 9, 9, 1, 1);
      tick;
      num1 = 10'd0;
      tick;
      chk("t3_hold_hund", 32'(hundreds), 9);
      chk("t3_hold_ovf",  32'(ovf), 1);
      req = 2'b10;
      conv(2'b00, -1, gid, lat, bc, dg);
      chk("t3c_lat", lat, 11);
      chk_res("t3c", 0, 0, 0, 0, 1);
      tick;

      // operand changed right after the grant edge
      req  = 2'b01;
      num0 = 10'd45;
      conv(2'b00, 678, gid, lat, bc, dg);
      chk("t4_lat", lat, 11);
      chk_res("t4", 0, 4, 5, 0, 0);
      tick;

      // reset during the 5th SHIFT cycle
      req  = 2'b10;
      num1 = 10'd500;
      tick;
      chk("t5_abort_gid", 32'(grant_id), 1);
      req = 2'b00;
      for (int i = 0; i < 4; i++) tick;
      reset = 1'b1;
      #1;
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_gid",  32'(grant_id), 0);
      chk("t5_rst_tens", 32'(tens), 0);
      chk("t5_rst_ones", 32'(ones), 0);
      chk("t5_rst_done", 32'(done), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      req  = 2'b01;
      num0 = 10'd7;
      conv(2'b00, -1, gid, lat, bc, dg);
      chk("t5_gid", gid, 0);
      chk("t5_lat", lat, 11);
      chk_res("t5", 0, 0, 7, 0, 0);
      tick;

      // request held one cycle past done is served again at once
      req  = 2'b01;
      num0 = 10'd300;
      conv(2'b01, -1, gid, lat, bc, dg);
      chk_res("t6a", 3, 0, 0, 0, 0);
      conv(2'b00, -1, gid, lat, bc, dg);
      chk("t6b_done_single", dg, 0);
      chk("t6b_gid", gid, 0);
      chk("t6b_lat", lat, 11);
      chk_res("t6b", 3, 0, 0, 0, 0);
      tick;
      chk("t6_busy_fall", 32'(busy), 0);
      chk("t6_done_single", 32'(done), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
